// File: rtl/trakball_encoder.sv
// PS/2 mouse packets to quadrature trackball emulation: per-axis accumulators drained one count per step tick.
// Optional joystick stepping is compiled in with TRAKBALL_JOY_EN.
module trakball_encoder #(
    parameter int ACC_W    = 12,
    parameter int STEP_DIV = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [24:0] ps2_mouse,
    input  logic        flip,
`ifdef TRAKBALL_JOY_EN
    input  logic [3:0]  joy_i,
`endif
    output logic [7:0]  trakball_o
);

    localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN  = -SAT_MAX;
    localparam logic [7:0]            DIV_LAST = 8'(STEP_DIV - 1);

    // Symmetric clamp: the most negative code is never produced.
    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] v);
        if (v > SAT_MAX) return SAT_MAX[ACC_W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[ACC_W-1:0];
        else return v[ACC_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] delta(input logic sgn, input logic [7:0] mag,
                                                      input logic neg);
        logic signed [8:0] d;
        d = {sgn, mag};
        if (neg) d = -d;
        return ACC_W'(d);
    endfunction

    function automatic logic signed [ACC_W-1:0] toward_zero(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1]) return a + ACC_W'(1);
        else if (a != '0) return a - ACC_W'(1);
        else return a;
    endfunction

    logic                    tog_q, pkt, tick;
    logic [7:0]              cnt;
    logic signed [ACC_W-1:0] acc_x, acc_y, acc_x_nxt, acc_y_nxt;
    logic signed [ACC_W-1:0] dx, dy, base_x, base_y;
    logic                    clk_x, clk_y, dir_x, dir_y;
    logic                    clk_x_nxt, clk_y_nxt, dir_x_nxt, dir_y_nxt;
    logic                    step_x, step_y, joy_x, joy_y, joy_dir_x, joy_dir_y;
    logic                    unused_bits;

    assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:0]};

    always_comb begin
        pkt       = ps2_mouse[24] != tog_q;
        tick      = cnt == DIV_LAST;
        dx        = pkt ? delta(ps2_mouse[4], ps2_mouse[15:8], flip) : '0;
        dy        = pkt ? delta(ps2_mouse[5], ps2_mouse[23:16], flip) : '0;
        joy_x     = 1'b0;
        joy_y     = 1'b0;
        joy_dir_x = 1'b0;
        joy_dir_y = 1'b0;
`ifdef TRAKBALL_JOY_EN
        joy_x     = tick && (joy_i[3] != joy_i[2]);
        joy_dir_x = joy_i[3];
        joy_y     = tick && (joy_i[0] != joy_i[1]);
        joy_dir_y = joy_i[0];
`endif
        // A joystick step overrides the drain for that tick; the packet delta still lands.
        step_x    = tick && !joy_x && (acc_x != '0);
        step_y    = tick && !joy_y && (acc_y != '0);
        base_x    = step_x ? toward_zero(acc_x) : acc_x;
        base_y    = step_y ? toward_zero(acc_y) : acc_y;
        acc_x_nxt = sat((ACC_W+1)'(base_x) + (ACC_W+1)'(dx));
        acc_y_nxt = sat((ACC_W+1)'(base_y) + (ACC_W+1)'(dy));
        clk_x_nxt = clk_x ^ (step_x | joy_x);
        clk_y_nxt = clk_y ^ (step_y | joy_y);
        dir_x_nxt = joy_x ? joy_dir_x : (step_x ? !acc_x[ACC_W-1] : dir_x);
        dir_y_nxt = joy_y ? joy_dir_y : (step_y ? !acc_y[ACC_W-1] : dir_y);
    end

    always_ff @(posedge clk_sys) begin
        tog_q <= ps2_mouse[24];
        if (reset) begin
            cnt   <= '0;
            acc_x <= '0;
            acc_y <= '0;
            clk_x <= 1'b0;
            clk_y <= 1'b0;
            dir_x <= 1'b0;
            dir_y <= 1'b0;
        end else begin
            cnt   <= tick ? '0 : cnt + 8'd1;
            acc_x <= acc_x_nxt;
            acc_y <= acc_y_nxt;
            clk_x <= clk_x_nxt;
            clk_y <= clk_y_nxt;
            dir_x <= dir_x_nxt;
            dir_y <= dir_y_nxt;
        end
    end

    assign trakball_o = {dir_x, dir_x, clk_x, clk_x, dir_y, dir_y, clk_y, clk_y};

endmodule

// File: tb/tb_trakball_encoder.sv
// Bench for trakball_encoder: vector table, hand-written corner sequences, and
// randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps
module tb_trakball_encoder;
    localparam int ACC_W    = 12;
    localparam int STEP_DIV = 4;
    localparam int MAXV     = (1 << (ACC_W - 1)) - 1;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        flip = 1'b0;
    logic [24:0] ps2_mouse = '0;
    logic [7:0]  trakball_o;
`ifdef TRAKBALL_JOY_EN
    logic [3:0]  joy_i = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    trakball_encoder #(.ACC_W(ACC_W), .STEP_DIV(STEP_DIV)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_mouse  (ps2_mouse),
        .flip       (flip),
`ifdef TRAKBALL_JOY_EN
        .joy_i      (joy_i),
`endif
        .trakball_o (trakball_o)
    );

    // Reference model state: signed counts held as plain integers.
    int m_acc_x, m_acc_y, m_phase;
    bit m_clk_x, m_dir_x, m_clk_y, m_dir_y, m_tog;

    function automatic int decode(bit s, bit [7:0] mag, bit f);
        int d;
        d = s ? int'(mag) - 256 : int'(mag);
        if (f) d = -d;
        return d;
    endfunction

    function automatic int clamp(int v);
        if (v > MAXV) return MAXV;
        if (v < -MAXV) return -MAXV;
        return v;
    endfunction

    task automatic axis(inout int acc, inout bit c, inout bit d, input bit tick,
                        input bit jpos, input bit jneg, input bit pkt, input int dl);
        if (tick) begin
            if (jpos != jneg) begin
                c = !c;
                d = jpos;
            end else if (acc != 0) begin
                c = !c;
                d = (acc > 0);
                acc = (acc > 0) ? acc - 1 : acc + 1;
            end
        end
        if (pkt) acc = clamp(acc + dl);
    endtask

    task automatic model_step();
        bit tick, pkt, jr, jl, jd, ju;
        if (reset) begin
            m_acc_x = 0; m_acc_y = 0; m_phase = 0;
            m_clk_x = 0; m_dir_x = 0; m_clk_y = 0; m_dir_y = 0;
            m_tog = ps2_mouse[24];
            return;
        end
        tick = (m_phase == STEP_DIV - 1);
        m_phase = (m_phase + 1) % STEP_DIV;
        pkt = (ps2_mouse[24] != m_tog);
        m_tog = ps2_mouse[24];
        {jr, jl, jd, ju} = 4'b0000;
`ifdef TRAKBALL_JOY_EN
        {jr, jl, jd, ju} = joy_i;
`endif
        axis(m_acc_x, m_clk_x, m_dir_x, tick, jr, jl, pkt,
             decode(ps2_mouse[4], ps2_mouse[15:8], flip));
        axis(m_acc_y, m_clk_y, m_dir_y, tick, ju, jd, pkt,
             decode(ps2_mouse[5], ps2_mouse[23:16], flip));
    endtask

    function automatic int m_out();
        return int'({m_dir_x, m_dir_x, m_clk_x, m_clk_x, m_dir_y, m_dir_y, m_clk_y, m_clk_y});
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic send(bit sx, bit [7:0] mx, bit sy, bit [7:0] my);
        ps2_mouse[4]     = sx;
        ps2_mouse[15:8]  = mx;
        ps2_mouse[5]     = sy;
        ps2_mouse[23:16] = my;
        ps2_mouse[24]    = ~ps2_mouse[24];
    endtask

    typedef struct {
        bit       sx;
        bit [7:0] mx;
        bit       sy;
        bit [7:0] my;
        bit       f;
        int       tx;
        int       ty;
        bit       dxe;
        bit       dye;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] prev;
        logic [7:0] exp_b;
        int tx, ty, last_x, last_y, bad_gap, changes;

        vecs[0] = '{1'b0, 8'h05, 1'b0, 8'h00, 1'b0,   5, 0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'hFD, 1'b1,   0, 3, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 253, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h07, 1'b1, 8'hFE, 1'b0,   7, 2, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h04, 1'b0, 8'h06, 1'b1,   4, 6, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0,   0, 0, 1'b0, 1'b0};

        // Reset state and idle quiet period
        do_reset();
        check("reset_out", int'(trakball_o), 0);
        changes = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (trakball_o != 8'h00) changes++;
        end
        check("idle_quiet", changes, 0);

        // Single-packet vectors: toggle counts, spacing and final pins
        for (int v = 0; v < 6; v++) begin
            do_reset();
            flip = vecs[v].f;
            send(vecs[v].sx, vecs[v].mx, vecs[v].sy, vecs[v].my);
            prev = trakball_o;
            tx = 0; ty = 0; last_x = -1; last_y = -1; bad_gap = 0;
            for (int i = 0; i < 1100; i++) begin
                cycle();
                if (trakball_o[5] != prev[5]) begin
                    tx++;
                    if (last_x >= 0 && i - last_x != STEP_DIV) bad_gap++;
                    last_x = i;
                end
                if (trakball_o[1] != prev[1]) begin
                    ty++;
                    if (last_y >= 0 && i - last_y != STEP_DIV) bad_gap++;
                    last_y = i;
                end
                prev = trakball_o;
            end
            exp_b = {vecs[v].dxe, vecs[v].dxe, vecs[v].tx[0], vecs[v].tx[0],
                     vecs[v].dye, vecs[v].dye, vecs[v].ty[0], vecs[v].ty[0]};
            check($sformatf("vec%0d_x_toggles", v), tx, vecs[v].tx);
            check($sformatf("vec%0d_y_toggles", v), ty, vecs[v].ty);
            check($sformatf("vec%0d_gap", v), bad_gap, 0);
            check($sformatf("vec%0d_pins", v), int'(trakball_o), int'(exp_b));
            flip = 1'b0;
        end

        // Back-to-back packets saturate, then drain exactly the clamp value
        do_reset();
        for (int k = 0; k < 20; k++) begin
            send(1'b0, 8'h7F, 1'b0, 8'h00);
            cycle();
        end
        check("sat_pos_acc", int'(dut.acc_x), 2047);
        prev = trakball_o;
        tx = 0;
        for (int i = 0; i < 2047 * STEP_DIV + 40; i++) begin
            cycle();
            if (trakball_o[5] != prev[5]) tx++;
            prev = trakball_o;
        end
        check("sat_pos_toggles", tx, 2047);
        check("sat_pos_drained", int'(dut.acc_x), 0);

        do_reset();
        for (int k = 0; k < 20; k++) begin
            send(1'b1, 8'h01, 1'b0, 8'h00);
            cycle();
        end
        check("sat_neg_acc", int'(dut.acc_x), -2047);

        // Packet coinciding with a step tick: step first, then add
        do_reset();
        send(1'b0, 8'h02, 1'b0, 8'h00);
        cycle();
        check("coinc_pre_acc", int'(dut.acc_x), 2);
        cycle();
        cycle();
        send(1'b0, 8'h01, 1'b0, 8'h00);
        cycle();
        check("coinc_acc", int'(dut.acc_x), 2);
        check("coinc_pins", int'(trakball_o), 8'hF0);

        // Reset mid-burst discards pending counts
        do_reset();
        send(1'b0, 8'h32, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        changes = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (trakball_o != 8'h00) changes++;
        end
        check("midburst_quiet", changes, 0);

`ifdef TRAKBALL_JOY_EN
        // Joystick right held: steps without touching the accumulator
        do_reset();
        joy_i = 4'b1000;
        prev = trakball_o;
        tx = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (trakball_o[5] != prev[5]) tx++;
            prev = trakball_o;
        end
        joy_i = 4'b0000;
        check("joy_toggles", tx, 10);
        check("joy_dir", int'(trakball_o[7]), 1);
        check("joy_acc", int'(dut.acc_x), 0);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bit sx, sy;
                bit [7:0] mx, my;
                sx = 1'($urandom_range(0, 1));
                sy = 1'($urandom_range(0, 1));
                mx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
                my = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
                if (sx && mx == 8'h00) mx = 8'h01;
                if (sy && my == 8'h00) my = 8'h01;
                send(sx, mx, sy, my);
            end
            if ($urandom_range(0, 63) == 0) flip = ~flip;
`ifdef TRAKBALL_JOY_EN
            if ($urandom_range(0, 31) == 0) joy_i = 4'($urandom_range(0, 15));
`endif
            reset = ($urandom_range(0, 599) == 0);
            cycle();
            check("rand_out", int'(trakball_o), m_out());
            check("rand_acc_x", int'(dut.acc_x), m_acc_x);
            check("rand_acc_y", int'(dut.acc_y), m_acc_y);
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trakball_encoder.md
TRAKBALL_ENCODER -- requirements
Module: trakball_encoder

Interface
REQ-001 The block SHALL have parameter ACC_W, default 12: width of each per-axis signed motion accumulator.
REQ-002 The block SHALL have parameter STEP_DIV, default 4: clk_sys cycles per quadrature step tick, legal range 2..255.
REQ-003 The block SHALL have port clk_sys, input, 1: the single system clock (12 MHz core clock).
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port ps2_mouse, input, 25: [24] packet toggle, [23:16] dy magnitude, [15:8] dx magnitude, [5] y sign, [4] x sign.
REQ-006 The block SHALL have port flip, input, 1: cocktail flip from the game core; inverts both axes.
REQ-007 The block SHALL have port trakball_o, output, 8: {dir_x,dir_x,clk_x,clk_x,dir_y,dir_y,clk_y,clk_y}, driving the core trackball input.
REQ-008 The block SHALL have port joy_i, input, 4: {right,left,down,up}, active-high, present only with TRAKBALL_JOY_EN.

Function
REQ-009 The block SHALL register ps2_mouse[24] into tog_q every cycle; a packet is accepted in any cycle where ps2_mouse[24] != tog_q.
REQ-010 The block SHALL form each per-axis delta as 9-bit two's complement {sign,magnitude}, negate it when flip=1, and sign-extend it to ACC_W.
REQ-011 The block SHALL add the delta into that axis's accumulator at the clock edge that detects the packet (one-cycle latency).
REQ-012 The block SHALL assert a step tick for one cycle when the divider counter reaches STEP_DIV-1; the counter then wraps to 0.
REQ-013 On a step tick, for each axis with a nonzero accumulator, the block SHALL move the accumulator one count toward zero, toggle clk_<axis>, and set dir_<axis> to 1 if the pre-step value was positive and 0 if negative.
REQ-014 On a step tick, an axis whose accumulator is zero SHALL hold clk_<axis> and dir_<axis> unchanged.
REQ-015 When a packet and a step tick coincide, the block SHALL apply the step to the old accumulator value first, then add the delta, then saturate.
REQ-016 Accumulator results SHALL saturate to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)] and SHALL never wrap.
REQ-017 The X and Y axes SHALL be fully independent; both may toggle on the same tick.
REQ-018 trakball_o SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-019 Under reset, the block SHALL clear both accumulators, dir_x, dir_y, clk_x, clk_y and the divider; trakball_o = 8'h00 in the cycle after reset is sampled high.
REQ-020 Under reset, tog_q SHALL load ps2_mouse[24], so no packet is accepted on the first cycle after reset.
REQ-021 Reset asserted mid-burst SHALL discard all pending counts; no further toggles occur until a new packet arrives.

Configuration
REQ-022 With TRAKBALL_JOY_EN defined, on each step tick an axis with exactly one of its joy_i directions held SHALL emit a step in that direction: right/up give dir=1, left/down give dir=0; clk toggles and the accumulator is left unchanged.
REQ-023 With TRAKBALL_JOY_EN defined, opposite directions held together on one axis SHALL be ignored and accumulator stepping proceeds normally.
REQ-024 With TRAKBALL_JOY_EN undefined, port joy_i and all joystick logic SHALL be absent, and behaviour SHALL be as in REQ-009..REQ-021.

Verification
REQ-025 Reset, then idle 100 cycles -> trakball_o stays 8'h00 and no clk toggles occur.
REQ-026 STEP_DIV=4, one packet dx=+5 (x sign=0, dx=8'h05), flip=0 -> exactly 5 clk_x toggles 4 cycles apart, bits[7:6]=2'b11, then quiet; Y bits unchanged.
REQ-027 Packet y sign=1, dy=8'hFD (-3), flip=1 -> exactly 3 clk_y toggles, bits[3:2]=2'b11.
REQ-028 Twenty back-to-back packets dx=+127 (x sign=0, dx=8'h7F) -> accumulator clamps at +2047, followed by exactly 2047 toggles.
REQ-029 Packet dx=+1 landing on a step tick with accumulator=+2 -> accumulator=+2 after the edge, and the toggle occurs on that tick.
REQ-030 TRAKBALL_JOY_EN defined, joy_i=4'b1000 held for 40 cycles with STEP_DIV=4 -> 10 clk_x toggles, dir_x=1, accumulator still 0.
